cpu_bus_arbiter: RTL and testbench
==================================

# cpu_bus_arbiter

Parametrised N-channel arbiter that merges several request/ack memory-bus initiators (instruction fetch, data port, debug/DMA) onto the single downstream memory bus used by the CPU. It is the successor of the single-initiator data bus: the same request/address/write/wstrb/wdata/rdata/ack handshake is kept, with these additions:
- configurable channel count and widths;
- round-robin or fixed-priority arbitration;
- a bus-timeout watchdog that terminates hung transactions with an error.

## Interface
Parameters:
- NUM_PORTS, 2, number of upstream channels (1..8); channel 0 is highest priority in fixed mode.
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width; multiple of 8.
- PRIORITY_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins).
- TIMEOUT, 0, cycles in BUSY before forced termination; 0 disables the watchdog.

Ports (the reset polarity and synchronicity are fixed: one clock; reset is asynchronous and active-high):
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- m_request  in  NUM_PORTS  per-channel request, held until acked.
- m_address  in  NUM_PORTS*ADDR_WIDTH  channel i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- m_write  in  NUM_PORTS  1 = write.
- m_wstrb  in  NUM_PORTS*DATA_WIDTH/8  byte strobes.
- m_wdata  in  NUM_PORTS*DATA_WIDTH  write data.
- m_rdata  out  DATA_WIDTH  read data, shared; valid only with an m_ack bit.
- m_ack  out  NUM_PORTS  one-cycle completion pulse to the granted channel.
- m_error  out  NUM_PORTS  one-cycle pulse coincident with m_ack on timeout.
- s_request  out  1  downstream request.
- s_address  out  ADDR_WIDTH  downstream address.
- s_write  out  1  downstream write.
- s_wstrb  out  DATA_WIDTH/8  downstream strobes.
- s_wdata  out  DATA_WIDTH  downstream write data.
- s_rdata  in  DATA_WIDTH  downstream read data, valid with s_ack.
- s_ack  in  1  downstream completion, one cycle.
- grant_id  out  clog2(NUM_PORTS) (min 1)  index of the current or last granted channel; for debug and performance counters.

## Operation
- FSM states: IDLE and BUSY.
- IDLE:
  - If any m_request bit is set, select a winner, register its address/write/wstrb/wdata into the s_* registers, set grant_id, and go to BUSY with s_request=1.
  - With no requests, stay in IDLE and hold s_request=0.
- Arbitration:
  - Round-robin: the search starts at (last_grant+1) mod NUM_PORTS and wraps around.
  - Fixed priority: the lowest-index requesting channel wins.
  - last_grant updates only when a grant is issued.
- BUSY: s_request stays 1 and the s_* fields are held stable. Upstream changes are ignored.
- Downstream completion (s_ack=1 in BUSY), combinationally in the same cycle:
  - m_ack[grant_id]=1 and m_rdata=s_rdata.
  - On the next edge: s_request=0, state returns to IDLE, and the watchdog clears.
- Requester obligations:
  - Hold its request and fields until it sees m_ack.
  - At the edge where m_ack=1, it may drop the request or present a new one.
  - The mandatory IDLE cycle after each transaction guarantees that a stale request is never re-granted.
- Watchdog (TIMEOUT>0):
  - A counter increments each BUSY cycle without s_ack.
  - When it reaches TIMEOUT-1 and s_ack is still 0, that cycle drives m_ack[grant_id]=1, m_error[grant_id]=1 and m_rdata=0, then goes to IDLE.
  - s_ack arriving in the same cycle as the timeout wins: normal ack, no error.
  - An s_ack received in IDLE (late ack after a timeout) is ignored and produces no m_ack.
- m_ack and m_error are 0 for every non-granted channel at all times, and m_ack is never set for more than one channel.
- NUM_PORTS=1: arbitration degenerates to pass-through with the registered stage; grant_id is always 0.

## Timing
- Reset values:
  - state=IDLE, s_request=0, s_address/s_wdata/s_wstrb/s_write=0.
  - grant_id=0, last_grant=NUM_PORTS-1 (so round-robin first serves channel 0), watchdog counter=0.
  - m_ack=0, m_error=0, m_rdata=0.
- Reset asserted mid-transaction clears state and s_request immediately (asynchronous). The downstream slave must tolerate the abandoned request.
- Latency: m_request seen at edge N gives s_request=1 after edge N. A zero-wait slave acks in cycle N+1, so m_ack pulses in cycle N+1. Total: 1 cycle of arbiter latency plus slave latency.
- Back-to-back throughput: one transaction per (slave latency + 2) cycles, because of the IDLE gap.
- The only combinational paths are s_ack→m_ack/m_error and s_rdata→m_rdata. All s_* outputs are registered.
- The watchdog counter is clog2(TIMEOUT+1) bits wide and saturates, so it never wraps.

## Test plan
- Single request, zero-wait slave, NUM_PORTS=2: ch0 read at 0x0000_1000 → s_request the cycle after, s_address=0x1000; slave acks with 0xDEADBEEF → m_ack=2'b01, m_rdata=0xDEADBEEF the same cycle, then one IDLE cycle.
- Round-robin fairness: ch0 and ch1 request continuously, 4 transactions → grant_id sequence 0,1,0,1. With PRIORITY_MODE=1 the sequence is 0,0,0,0.
- Write path: ch1 writes 0x1234_5678 to 0x20 with wstrb 4'b0011 while ch0 is idle → s_write=1, s_wstrb=4'b0011, s_wdata=0x12345678, all held stable across a 3-cycle slave wait.
- Timeout with TIMEOUT=8 and a slave that never acks → m_ack[0]=m_error[0]=1 and m_rdata=0 exactly on the 8th BUSY cycle. A late s_ack two cycles later produces no m_ack. s_ack coincident with the 8th cycle → m_error=0.
- Reset mid-BUSY: assert reset during a pending ch1 transaction → s_request=0 with no clock edge. After release, the first grant goes to ch0 when both channels request.
- NUM_PORTS=4 wrap-around: last grant ch3, requests on ch1 and ch2 → ch1 granted next, then ch2.

Source files
------------

// File: rtl/cpu_bus_arbiter.sv
// cpu_bus_arbiter: merges NUM_PORTS request/ack initiators onto one downstream
// memory bus. The arbitration is round-robin or fixed priority, and there is
// one registered request stage. An optional watchdog ends a hung transaction
// with an error pulse.
module cpu_bus_arbiter #(
    parameter int NUM_PORTS     = 2,
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int PRIORITY_MODE = 0,
    parameter int TIMEOUT       = 0,
    localparam int ID_W         = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
    localparam int STRB_W       = DATA_WIDTH / 8
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [NUM_PORTS-1:0]           m_request,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] m_address,
    input  logic [NUM_PORTS-1:0]           m_write,
    input  logic [NUM_PORTS*STRB_W-1:0]    m_wstrb,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] m_wdata,
    output logic [DATA_WIDTH-1:0]          m_rdata,
    output logic [NUM_PORTS-1:0]           m_ack,
    output logic [NUM_PORTS-1:0]           m_error,
    output logic                           s_request,
    output logic [ADDR_WIDTH-1:0]          s_address,
    output logic                           s_write,
    output logic [STRB_W-1:0]              s_wstrb,
    output logic [DATA_WIDTH-1:0]          s_wdata,
    input  logic [DATA_WIDTH-1:0]          s_rdata,
    input  logic                           s_ack,
    output logic [ID_W-1:0]                grant_id
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // The watchdog counter saturates at its all-ones value, so it never wraps.
    localparam int              CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CNT_W-1:0] WD_MAX  = '1;

    state_t           state;
    state_t           state_next;
    logic [ID_W-1:0]  last_grant;
    logic [ID_W-1:0]  winner;
    logic             grant_load;
    logic             timed_out;
    logic [CNT_W-1:0] wd_count;

    // The watchdog fires when the counter reaches its last BUSY cycle.
    assign timed_out = (TIMEOUT > 0) && (wd_count == WD_LAST);

    // Pick the channel to serve from the current request vector.
    always_comb begin
        logic [ID_W-1:0] cand;
        // NOTE: every variable written here gets a default first; any path that
        // leaves one unassigned would make synthesis infer a latch.
        winner = '0;
        cand   = '0;
        if (PRIORITY_MODE != 0) begin
            // Walk from the highest index down so the lowest requester is kept last.
            for (int i = NUM_PORTS - 1; i >= 0; i--) begin
                cand = ID_W'(i);
                if (m_request[cand]) winner = cand;
            end
        end else begin
            // Walk the offsets from far to near so the nearest requester after
            // last_grant is kept.
            for (int off = NUM_PORTS; off >= 1; off--) begin
                cand = ID_W'((int'(last_grant) + off) % NUM_PORTS);
                if (m_request[cand]) winner = cand;
            end
        end
    end

    // Next state, plus the combinational ack/error/rdata returned to the granted channel.
    always_comb begin
        state_next = state;
        grant_load = 1'b0;
        m_ack      = '0;
        m_error    = '0;
        m_rdata    = '0;
        case (state)
            IDLE: begin
                if (|m_request) begin
                    state_next = BUSY;
                    grant_load = 1'b1;
                end
            end
            BUSY: begin
                if (s_ack) begin
                    // A real ack wins over a timeout in the same cycle.
                    m_ack[grant_id] = 1'b1;
                    m_rdata         = s_rdata;
                    state_next      = IDLE;
                end else if (timed_out) begin
                    m_ack[grant_id]   = 1'b1;
                    m_error[grant_id] = 1'b1;
                    state_next        = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments, so every flop
        // samples values from before the edge regardless of block order.
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Downstream request and the transaction fields captured at grant time.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s_request  <= 1'b0;
            s_address  <= '0;
            s_write    <= 1'b0;
            s_wstrb    <= '0;
            s_wdata    <= '0;
            grant_id   <= '0;
            last_grant <= ID_W'(NUM_PORTS - 1);
        end else begin
            s_request <= (state_next == BUSY);
            if (grant_load) begin
                s_address  <= m_address[int'(winner) * ADDR_WIDTH +: ADDR_WIDTH];
                s_write    <= m_write[winner];
                s_wstrb    <= m_wstrb[int'(winner) * STRB_W +: STRB_W];
                s_wdata    <= m_wdata[int'(winner) * DATA_WIDTH +: DATA_WIDTH];
                grant_id   <= winner;
                last_grant <= winner;
            end
        end
    end

    // Watchdog: count the BUSY cycles that do not complete, and clear when the transaction ends.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wd_count <= '0;
        end else if (state == BUSY && state_next == BUSY) begin
            if (wd_count != WD_MAX) wd_count <= wd_count + 1'b1;
        end else begin
            wd_count <= '0;
        end
    end

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Self-checking bench for cpu_bus_arbiter. It runs two 4-channel instances:
// round-robin with an 8-cycle watchdog, and fixed priority without a watchdog.
// A transaction-level model predicts grants, held fields, acks and timeouts.
module tb_cpu_bus_arbiter;

    localparam int NP = 4;

    typedef struct {
        bit          valid;
        logic [31:0] addr;
        bit          write;
        logic [3:0]  strb;
        logic [31:0] data;
    } txn_t;

    logic clock = 1'b0;
    logic reset = 1'b1;

    logic [NP-1:0]    m_request [2];
    logic [NP*32-1:0] m_address [2];
    logic [NP-1:0]    m_write   [2];
    logic [NP*4-1:0]  m_wstrb   [2];
    logic [NP*32-1:0] m_wdata   [2];
    logic [31:0]      m_rdata   [2];
    logic [NP-1:0]    m_ack     [2];
    logic [NP-1:0]    m_error   [2];
    logic             s_request [2];
    logic [31:0]      s_address [2];
    logic             s_write   [2];
    logic [3:0]       s_wstrb   [2];
    logic [31:0]      s_wdata   [2];
    logic [31:0]      s_rdata   [2];
    logic             s_ack     [2];
    logic [1:0]       grant_id  [2];

    int checks = 0;
    int errors = 0;

    // Model state: requesters, and the arbiter seen as one transaction in flight.
    txn_t req [2][NP];
    bit   busy [2];
    int   gnt  [2];   // channel owning the transaction in flight
    int   gid  [2];   // expected grant_id (current or last granted)
    int   last [2];   // last granted channel for round-robin
    int   bc   [2];   // BUSY cycles elapsed in the current transaction
    int   lat  [2];   // planned slave latency in BUSY cycles
    int   force_lat = -1;

    always #5 clock = ~clock;

    cpu_bus_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(32), .DATA_WIDTH(32),
                      .PRIORITY_MODE(0), .TIMEOUT(8)) dut_rr (
        .clock(clock), .reset(reset),
        .m_request(m_request[0]), .m_address(m_address[0]), .m_write(m_write[0]),
        .m_wstrb(m_wstrb[0]), .m_wdata(m_wdata[0]), .m_rdata(m_rdata[0]),
        .m_ack(m_ack[0]), .m_error(m_error[0]),
        .s_request(s_request[0]), .s_address(s_address[0]), .s_write(s_write[0]),
        .s_wstrb(s_wstrb[0]), .s_wdata(s_wdata[0]), .s_rdata(s_rdata[0]),
        .s_ack(s_ack[0]), .grant_id(grant_id[0])
    );

    cpu_bus_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(32), .DATA_WIDTH(32),
                      .PRIORITY_MODE(1), .TIMEOUT(0)) dut_fp (
        .clock(clock), .reset(reset),
        .m_request(m_request[1]), .m_address(m_address[1]), .m_write(m_write[1]),
        .m_wstrb(m_wstrb[1]), .m_wdata(m_wdata[1]), .m_rdata(m_rdata[1]),
        .m_ack(m_ack[1]), .m_error(m_error[1]),
        .s_request(s_request[1]), .s_address(s_address[1]), .s_write(s_write[1]),
        .s_wstrb(s_wstrb[1]), .s_wdata(s_wdata[1]), .s_rdata(s_rdata[1]),
        .s_ack(s_ack[1]), .grant_id(grant_id[1])
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int dut_timeout(input int d);
        return (d == 0) ? 8 : 0;
    endfunction

    // Slave latency plan: short waits, sometimes exactly on the timeout cycle,
    // and sometimes never (only on the instance that has a watchdog).
    function automatic int pick_lat(input int d);
        int r;
        if (force_lat >= 0) return force_lat;
        r = int'($urandom_range(9));
        if (d == 1 || r < 6) return r % 4;
        if (r < 8) return 7;
        return 1000;
    endfunction

    // The arbitration rules applied directly to the set of requesting channels.
    function automatic int pick_winner(input int d);
        if (d == 1) begin
            for (int c = 0; c < NP; c++) if (req[d][c].valid) return c;
        end else begin
            for (int k = 1; k <= NP; k++) if (req[d][(last[d] + k) % NP].valid) return (last[d] + k) % NP;
        end
        return -1;
    endfunction

    task automatic new_txn(input int d, input int c);
        req[d][c].valid = 1'b1;
        req[d][c].addr  = $urandom;
        req[d][c].write = 1'($urandom_range(1));
        req[d][c].strb  = 4'($urandom_range(15));
        req[d][c].data  = $urandom;
    endtask

    task automatic drive(input int d);
        for (int c = 0; c < NP; c++) begin
            m_request[d][c]           = req[d][c].valid;
            m_address[d][c*32 +: 32]  = req[d][c].addr;
            m_write[d][c]             = req[d][c].write;
            m_wstrb[d][c*4 +: 4]      = req[d][c].strb;
            m_wdata[d][c*32 +: 32]    = req[d][c].data;
        end
    endtask

    task automatic reset_model();
        for (int d = 0; d < 2; d++) begin
            busy[d] = 1'b0; gnt[d] = 0; gid[d] = 0; last[d] = NP - 1; bc[d] = 0; lat[d] = 0;
            for (int c = 0; c < NP; c++) req[d][c] = '{1'b0, 32'h0, 1'b0, 4'h0, 32'h0};
            drive(d);
            s_ack[d]   = 1'b0;
            s_rdata[d] = '0;
        end
    endtask

    // One clock cycle on instance d: drive inputs at negedge, check, advance the model.
    task automatic step(input int d, input int gen_pct);
        bit          tmo, fire;
        logic [3:0]  exp_ack, exp_err;
        logic [31:0] exp_rdata;
        int          w;
        string       p;
        @(negedge clock);
        p = $sformatf("d%0d ", d);
        for (int c = 0; c < NP; c++)
            if (!req[d][c].valid && int'($urandom_range(99)) < gen_pct) new_txn(d, c);
        drive(d);
        if (busy[d]) s_ack[d] = (bc[d] == lat[d]);
        else         s_ack[d] = ($urandom_range(9) < 3);   // stray or late acks must be ignored
        s_rdata[d] = $urandom;
        #1;
        tmo       = busy[d] && !s_ack[d] && dut_timeout(d) > 0 && bc[d] == dut_timeout(d) - 1;
        fire      = busy[d] && (s_ack[d] || tmo);
        exp_ack   = fire ? 4'(1 << gnt[d]) : 4'h0;
        exp_err   = tmo  ? 4'(1 << gnt[d]) : 4'h0;
        exp_rdata = (busy[d] && s_ack[d]) ? s_rdata[d] : 32'h0;
        check({p, "s_request"}, s_request[d], busy[d]);
        check({p, "m_ack"},     m_ack[d],     exp_ack);
        check({p, "m_error"},   m_error[d],   exp_err);
        check({p, "m_rdata"},   m_rdata[d],   exp_rdata);
        check({p, "grant_id"},  grant_id[d],  gid[d]);
        if (busy[d]) begin
            check({p, "s_address"}, s_address[d], req[d][gnt[d]].addr);
            check({p, "s_write"},   s_write[d],   req[d][gnt[d]].write);
            check({p, "s_wstrb"},   s_wstrb[d],   req[d][gnt[d]].strb);
            check({p, "s_wdata"},   s_wdata[d],   req[d][gnt[d]].data);
        end
        if (busy[d]) begin
            if (fire) begin
                busy[d] = 1'b0;
                req[d][gnt[d]].valid = 1'b0;   // requester drops at the acking edge
            end else begin
                bc[d]++;
            end
        end else begin
            w = pick_winner(d);
            if (w >= 0) begin
                busy[d] = 1'b1; gnt[d] = w; gid[d] = w; last[d] = w; bc[d] = 0;
                lat[d]  = pick_lat(d);
            end
        end
    endtask

    initial begin
        reset_model();
        reset = 1'b1;
        #12;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("d%0d reset s_request", d), s_request[d], 0);
            check($sformatf("d%0d reset s_address", d), s_address[d], 0);
            check($sformatf("d%0d reset s_write", d),   s_write[d],   0);
            check($sformatf("d%0d reset s_wstrb", d),   s_wstrb[d],   0);
            check($sformatf("d%0d reset s_wdata", d),   s_wdata[d],   0);
            check($sformatf("d%0d reset grant_id", d),  grant_id[d],  0);
            check($sformatf("d%0d reset m_ack", d),     m_ack[d],     0);
            check($sformatf("d%0d reset m_error", d),   m_error[d],   0);
            check($sformatf("d%0d reset m_rdata", d),   m_rdata[d],   0);
        end
        @(negedge clock);
        reset = 1'b0;

        // Round-robin with watchdog: light, then heavy contention.
        for (int i = 0; i < 600; i++)  step(0, 20);
        for (int i = 0; i < 1200; i++) step(0, 70);
        // Drain, then abandon a pending ch1 transaction with an asynchronous reset.
        for (int c = 0; c < NP; c++) if (!busy[0] || c != gnt[0]) req[0][c].valid = 1'b0;
        for (int i = 0; i < 12 && busy[0]; i++) step(0, 0);
        check("d0 drained", busy[0], 0);
        force_lat = 1000;
        new_txn(0, 1);
        for (int i = 0; i < 5 && !busy[0]; i++) step(0, 0);
        step(0, 0);
        step(0, 0);
        @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        check("d0 async reset s_request", s_request[0], 0);
        check("d0 async reset m_ack", m_ack[0], 0);
        #10;
        @(negedge clock);
        reset = 1'b0;
        reset_model();
        force_lat = 0;
        new_txn(0, 0);
        new_txn(0, 1);
        step(0, 0);
        step(0, 0);
        check("d0 first grant after reset", grant_id[0], 0);
        force_lat = -1;
        for (int i = 0; i < 200; i++) step(0, 60);

        // Fixed priority instance.
        for (int i = 0; i < 800; i++) step(1, 60);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL sim_timeout got=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule
